// File: rtl/gpio_in_pkg.sv
// Shared constants and types for the gpio_in CSR block.
// Register offsets are decoded from csr_a[3:0]; the bank lives in csr_a[13:10].
package gpio_in_pkg;

    localparam int unsigned GPIO_IN_DW = 32;

    localparam logic [3:0] GPIO_IN_REG_IN      = 4'h0;
    localparam logic [3:0] GPIO_IN_REG_PENDING = 4'h1;
    localparam logic [3:0] GPIO_IN_REG_RISE_EN = 4'h2;
    localparam logic [3:0] GPIO_IN_REG_FALL_EN = 4'h3;
    localparam logic [3:0] GPIO_IN_REG_IRQ_EN  = 4'h4;

    typedef logic [GPIO_IN_DW-1:0] gpio_word_t;

    // Write-1-to-clear with new events taking priority over a same-cycle clear.
    function automatic gpio_word_t gpio_in_pending_next(
        input gpio_word_t cur,
        input gpio_word_t clr,
        input gpio_word_t set
    );
        return (cur & ~clr) | set;
    endfunction

endpackage

// File: rtl/gpio_in_debounce.sv
// Two-flop synchroniser followed by an optional tick-sampled debouncer.
// A bit only moves to a new level after two consecutive ticks agree on it.
module gpio_in_debounce
    import gpio_in_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_DIV = 16'd0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  gpio_word_t i_pins,
    output gpio_word_t o_stable
);

    gpio_word_t r_sync1;
    gpio_word_t r_sync2;
    gpio_word_t r_stable;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_pins;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_DIV == 16'd0) begin : g_bypass
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_stable <= '0;
                end else begin
                    r_stable <= r_sync2;
                end
            end
        end else begin : g_debounce
            logic [15:0] r_presc;
            gpio_word_t  r_sample;
            logic        w_tick;
            gpio_word_t  w_agree;

            assign w_tick  = (r_presc == DEBOUNCE_DIV - 16'd1);
            // Compare against the previous tick's sample, not the one being taken now.
            assign w_agree = ~(r_sync2 ^ r_sample);

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_presc  <= '0;
                    r_sample <= '0;
                    r_stable <= '0;
                end else begin
                    r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
                    if (w_tick) begin
                        r_sample <= r_sync2;
                        r_stable <= (r_stable & ~w_agree) | (r_sync2 & w_agree);
                    end
                end
            end
        end
    endgenerate

    assign o_stable = r_stable;

endmodule

// File: rtl/gpio_in.sv
// 32-bit GPIO input block on the CSR bus: debounced pin state, W1C edge
// pending bits with per-direction enables, and a registered level interrupt.
module gpio_in
    import gpio_in_pkg::*;
#(
    parameter logic [3:0]  csr_addr     = 4'h0,
    parameter logic [15:0] DEBOUNCE_DIV = 16'd0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [13:0]           csr_a,
    input  logic                  csr_we,
    input  logic [GPIO_IN_DW-1:0] csr_di,
    output logic [GPIO_IN_DW-1:0] csr_do,
    input  logic [GPIO_IN_DW-1:0] gpio_inputs,
    output logic                  irq
);

    gpio_word_t w_stable;
    gpio_word_t r_stable_prev;
    gpio_word_t r_pending;
    gpio_word_t r_rise_en;
    gpio_word_t r_fall_en;
    gpio_word_t r_irq_en;

    gpio_word_t w_rise;
    gpio_word_t w_fall;
    gpio_word_t w_set;
    gpio_word_t w_clr;
    gpio_word_t w_rdata;
    logic       w_sel;
    logic       w_wr;
    logic [3:0] w_reg;
    logic       w_unused_addr;

    gpio_in_debounce #(
        .DEBOUNCE_DIV(DEBOUNCE_DIV)
    ) u_debounce (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst),
        .i_pins  (gpio_inputs),
        .o_stable(w_stable)
    );

    assign w_sel         = (csr_a[13:10] == csr_addr);
    assign w_reg         = csr_a[3:0];
    assign w_wr          = w_sel & csr_we;
    assign w_unused_addr = ^csr_a[9:4];

    assign w_rise = w_stable & ~r_stable_prev;
    assign w_fall = ~w_stable & r_stable_prev;
    assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr  = (w_wr && (w_reg == GPIO_IN_REG_PENDING)) ? csr_di : '0;

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            GPIO_IN_REG_IN:      w_rdata = w_stable;
            GPIO_IN_REG_PENDING: w_rdata = r_pending;
            GPIO_IN_REG_RISE_EN: w_rdata = r_rise_en;
            GPIO_IN_REG_FALL_EN: w_rdata = r_fall_en;
            GPIO_IN_REG_IRQ_EN:  w_rdata = r_irq_en;
            default:             w_rdata = '0;
        endcase
    end

    // Read data reflects the pre-write register value; write lands on the same edge.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            csr_do    <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_irq_en  <= '0;
        end else begin
            csr_do <= w_sel ? w_rdata : '0;
            if (w_wr) begin
                case (w_reg)
                    GPIO_IN_REG_RISE_EN: r_rise_en <= csr_di;
                    GPIO_IN_REG_FALL_EN: r_fall_en <= csr_di;
                    GPIO_IN_REG_IRQ_EN:  r_irq_en  <= csr_di;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_stable_prev <= '0;
            r_pending     <= '0;
            irq           <= 1'b0;
        end else begin
            r_stable_prev <= w_stable;
            r_pending     <= gpio_in_pending_next(r_pending, w_clr, w_set);
            irq           <= |(r_pending & r_irq_en);
        end
    end

endmodule

// File: tb/tb_gpio_in.sv
// Scoreboarded bench for gpio_in: a bypass instance (bank 0) tracked every cycle
// by a pin-history reference model, plus a DEBOUNCE_DIV=4 instance (bank 5).
module tb_gpio_in;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] pins0, pins1;
    logic [31:0] do0, do1;
    logic        irq0, irq1;

    always #5 sys_clk = ~sys_clk;

    gpio_in #(.csr_addr(4'h0), .DEBOUNCE_DIV(16'd0)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we),
        .csr_di(csr_di), .csr_do(do0), .gpio_inputs(pins0), .irq(irq0)
    );

    gpio_in #(.csr_addr(4'h5), .DEBOUNCE_DIV(16'd4)) dut_db (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .csr_a(csr_a), .csr_we(csr_we),
        .csr_di(csr_di), .csr_do(do1), .gpio_inputs(pins1), .irq(irq1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: sig 0 = bypass csr_do, 1 = bypass irq, 2 = debounce csr_do.
    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    always @(negedge sys_clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.sig)
                0:       check("sb_csr_do", do0, e.exp);
                1:       check("sb_irq", {31'b0, irq0}, e.exp);
                default: check("sb_db_csr_do", do1, e.exp);
            endcase
        end
    end

    // Reference model: the pin value sampled at each edge since the last reset
    // release; the stable value seen at edge k is the pin sampled at edge k-3.
    logic [31:0] hist [0:8191];
    int          e0 = 0;
    logic [31:0] m_pend, m_rise, m_fall, m_irqen;

    function automatic logic [31:0] sampled(input int k);
        if (k >= e0 && k >= 0) return hist[k];
        return '0;
    endfunction

    localparam logic [13:0] IDLE = 14'h3C00;

    task automatic cycle(input logic [13:0] a, input logic we, input logic [31:0] di);
        int          k;
        logic [31:0] st, stp, setv, clrv, rd;
        logic        sel;
        k = cyc + 1;
        if (k > 8191) begin
            $display("FAIL cycle_budget: got %0d, expected below 8192", k);
            $fatal(1);
        end
        csr_a  = a;
        csr_we = we;
        csr_di = di;
        hist[k] = pins0;
        st   = sampled(k - 3);
        stp  = sampled(k - 4);
        setv = ((st & ~stp) & m_rise) | ((~st & stp) & m_fall);
        sel  = (a[13:10] == 4'h0);
        rd   = '0;
        if (sel) begin
            case (a[3:0])
                4'h0:    rd = st;
                4'h1:    rd = m_pend;
                4'h2:    rd = m_rise;
                4'h3:    rd = m_fall;
                4'h4:    rd = m_irqen;
                default: rd = '0;
            endcase
        end
        clrv = (sel && we && a[3:0] == 4'h1) ? di : '0;
        sb.push_back('{cyc: k, sig: 1, exp: {31'b0, |(m_pend & m_irqen)}});
        sb.push_back('{cyc: k, sig: 0, exp: rd});
        if (a[13:10] != 4'h5) sb.push_back('{cyc: k, sig: 2, exp: 32'h0});
        m_pend = (m_pend & ~clrv) | setv;
        if (sel && we) begin
            case (a[3:0])
                4'h2:    m_rise  = di;
                4'h3:    m_fall  = di;
                4'h4:    m_irqen = di;
                default: ;
            endcase
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(IDLE, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [3:0] bank, input logic [3:0] off, input logic [31:0] d);
        cycle({bank, 6'b0, off}, 1'b1, d);
    endtask

    task automatic rd(input logic [3:0] bank, input logic [3:0] off, output logic [31:0] d);
        cycle({bank, 6'b0, off}, 1'b0, 32'h0);
        d = (bank == 4'h5) ? do1 : do0;
    endtask

    task automatic release_reset();
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        e0      = cyc + 1;
        m_pend  = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_irqen = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  offs [6];
        logic        seen;
        logic [3:0]  bk, off;
        int          r;

        sys_rst = 1'b0;
        csr_a   = IDLE;
        csr_we  = 1'b0;
        csr_di  = '0;
        pins0   = '0;
        pins1   = '0;
        m_pend  = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_irqen = '0;
        repeat (3) @(posedge sys_clk);
        release_reset();

        // Reset state
        offs = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7};
        foreach (offs[i]) begin
            rd(4'h0, offs[i], d);
            check("reset_read", d, 32'h0);
        end
        check("reset_irq", {31'b0, irq0}, 32'h0);

        // Bypass rising edge: irq four edges after the pin is sampled
        wr(4'h0, 4'h2, 32'h1);
        wr(4'h0, 4'h4, 32'h1);
        pins0[0] = 1'b1;
        idle(4);
        check("rise_irq_early", {31'b0, irq0}, 32'h0);
        idle(1);
        check("rise_irq", {31'b0, irq0}, 32'h1);
        rd(4'h0, 4'h1, d);
        check("rise_pending", d, 32'h1);
        rd(4'h0, 4'h0, d);
        check("rise_in", d, 32'h1);

        // W1C and set-beats-clear collision
        wr(4'h0, 4'h2, 32'h3);
        pins0[1] = 1'b1;
        idle(4);
        rd(4'h0, 4'h1, d);
        check("w1c_before", d, 32'h3);
        wr(4'h0, 4'h1, 32'h1);
        rd(4'h0, 4'h1, d);
        check("w1c_after", d, 32'h2);
        pins0[0] = 1'b0;
        idle(5);
        pins0[0] = 1'b1;
        idle(3);
        wr(4'h0, 4'h1, 32'h1);
        rd(4'h0, 4'h1, d);
        check("w1c_collision", d, 32'h3);

        // Falling edge, masking, and irq drop on IRQ_EN clear
        wr(4'h0, 4'h1, 32'hFFFF_FFFF);
        wr(4'h0, 4'h3, 32'h8000_0000);
        pins0[31] = 1'b1;
        idle(5);
        pins0[31] = 1'b0;
        idle(5);
        rd(4'h0, 4'h1, d);
        check("fall_pending", d, 32'h8000_0000);
        wr(4'h0, 4'h4, 32'h8000_0000);
        idle(1);
        check("fall_irq", {31'b0, irq0}, 32'h1);
        wr(4'h0, 4'h4, 32'h0);
        check("irqen_clr_same", {31'b0, irq0}, 32'h1);
        idle(1);
        check("irqen_clr_next", {31'b0, irq0}, 32'h0);
        rd(4'h0, 4'h1, d);
        check("irqen_clr_retained", d, 32'h8000_0000);

        // Debounced instance: glitch rejection then settled level
        wr(4'h5, 4'h2, 32'h20);
        wr(4'h5, 4'h3, 32'h20);
        idle(8);
        pins1[5] = 1'b1;
        idle(3);
        pins1[5] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rd(4'h5, 4'h0, d);
            check("db_glitch_in", d, 32'h0);
        end
        rd(4'h5, 4'h1, d);
        check("db_glitch_pending", d, 32'h0);
        pins1[5] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rd(4'h5, 4'h0, d);
            check("db_early_in", d, 32'h0);
        end
        seen = 1'b0;
        for (int i = 7; i < 13 && !seen; i++) begin
            rd(4'h5, 4'h0, d);
            if (d == 32'h20) seen = 1'b1;
        end
        check("db_settle", {31'b0, seen}, 32'h1);
        idle(3);
        rd(4'h5, 4'h1, d);
        check("db_pending", d, 32'h20);
        check("db_irq", {31'b0, irq1}, 32'h0);

        // Async reset with pending = FF
        wr(4'h0, 4'h1, 32'hFFFF_FFFF);
        wr(4'h0, 4'h2, 32'hFF);
        wr(4'h0, 4'h3, 32'hFF);
        pins0[7:0] = pins0[7:0] ^ 8'hFF;
        idle(4);
        wr(4'h0, 4'h4, 32'hFF);
        idle(1);
        rd(4'h0, 4'h1, d);
        check("pre_reset_pending", d, 32'hFF);
        check("pre_reset_irq", {31'b0, irq0}, 32'h1);
        @(negedge sys_clk);
        #1;
        sys_rst = 1'b0;
        #1;
        check("async_csr_do", do0, 32'h0);
        check("async_irq", {31'b0, irq0}, 32'h0);
        check("async_db_csr_do", do1, 32'h0);
        repeat (3) @(posedge sys_clk);
        release_reset();
        rd(4'h0, 4'h1, d);
        check("post_reset_pending", d, 32'h0);
        rd(4'h5, 4'h1, d);
        check("post_reset_db_pending", d, 32'h0);

        // Randomised traffic on the bypass instance
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) pins0 = pins0 ^ ($urandom & $urandom);
            bk  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(6, 15)) : 4'h0;
            off = 4'($urandom_range(0, 7));
            r   = int'($urandom_range(0, 9));
            if (r < 3)
                idle(1);
            else if (r < 6)
                cycle({bk, 6'($urandom), off}, 1'b0, 32'h0);
            else if (r == 9)
                cycle({bk, 6'($urandom), 4'h1}, 1'b1, $urandom);
            else
                cycle({bk, 6'($urandom), off}, 1'b1, $urandom & $urandom);
        end

        idle(2);
        @(negedge sys_clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_in.md
Name: gpio_in

Overview:
32-bit general-purpose input block. It is the input-direction counterpart of the existing CSR-driven GPIO output block and sits on the same CSR bus.
- Synchronises external pins into sys_clk, with optional debounce.
- Detects rising and falling edges into write-1-to-clear pending bits.
- Raises a level interrupt to the CPU.

Parameters:
csr_addr, 4'h0, CSR bank select; block responds when csr_a[13:10] == csr_addr
DEBOUNCE_DIV, 16'd0, debounce sample period in sys_clk cycles; 0 = debounce bypassed

Ports:
sys_clk  input  1  system clock, all logic rising-edge
sys_rst  input  1  reset, asynchronous, active-low (asserted when 0)
csr_a  input  14  CSR address; [13:10] bank, [3:0] register
csr_we  input  1  CSR write strobe
csr_di  input  32  CSR write data
csr_do  output  32  CSR read data, registered
gpio_inputs  input  32  external pins, asynchronous to sys_clk
irq  output  1  level interrupt, registered

Behaviour:
- Reset (sys_rst=0, async): csr_do, irq, sync stages, stable, stable_prev, pending, rise_en, fall_en, irq_en and prescaler all clear to 0.
- Register map at csr_a[3:0]; any other offset reads 0 and ignores writes:
  - 0x0 IN: RO, debounced stable value.
  - 0x1 PENDING: read value; write 1 clears that bit, write 0 has no effect.
  - 0x2 RISE_EN: RW.
  - 0x3 FALL_EN: RW.
  - 0x4 IRQ_EN: RW.
- CSR read: csr_do is registered, 1-cycle latency. When the bank is selected, csr_do takes the addressed register's pre-write value; in every other cycle csr_do = 0.
- CSR write: takes effect at the same edge the strobe is sampled. There is no handshake; the bus assumes single-cycle access.
- Synchroniser: 2-FF per bit (sync1, sync2).
- Debounce bypass (DEBOUNCE_DIV = 0): stable <= sync2 every cycle.
- Debounce enabled (DEBOUNCE_DIV > 0):
  - Prescaler counts 0..DEBOUNCE_DIV-1 and wraps. tick = 1 in the cycle the count equals DEBOUNCE_DIV-1.
  - On tick: sample <= sync2, and for each bit, if sync2 == sample then stable <= sync2.
  - Result: a change needs two consecutive agreeing ticks. Glitches shorter than one period never reach stable.
- Edge detect: stable_prev <= stable every cycle.
  - rise = stable & ~stable_prev; fall = ~stable & stable_prev.
  - set = (rise & rise_en) | (fall & fall_en).
- Pending update: pending <= (pending & ~clr) | set, where clr = csr_di when a PENDING write is selected, else 0. If set and clear hit the same bit in the same cycle, set wins.
- irq <= |(pending & irq_en).
- Latency in bypass mode, pin change sampled at edge N:
  - sync2 at N+1, stable at N+2, pending at N+3, irq at N+4.
  - IN read issued at edge N+3 returns the new value on csr_do after N+3.
- Enable writes:
  - Changing RISE_EN/FALL_EN never sets or clears pending by itself.
  - Clearing IRQ_EN drops irq next cycle; pending is retained.
- Post-reset: stable starts at 0, so a pin held high produces a rise event ~2 cycles after reset release. It is latched only if rise_en is already set, which it cannot be after reset.
- Reset mid-debounce: prescaler and sample return to 0; debounce restarts cleanly.

Decomposition:
- Package gpio_in_pkg:
  - Register offset constants (GPIO_IN_REG_IN=4'h0, _PENDING=4'h1, _RISE_EN=4'h2, _FALL_EN=4'h3, _IRQ_EN=4'h4).
  - Data width constant 32.
- Sub-module gpio_in_debounce holds the synchroniser, prescaler and sample/stable logic, with interface gpio_inputs -> stable. The top level holds the CSR decode, edge detect, pending and irq logic.

Test Plan:
- Reset: after release, read offsets 0x0–0x4 and 0x7 -> all return 32'h0; irq = 0.
- Bypass rising edge: write RISE_EN=32'h1, IRQ_EN=32'h1; drive gpio_inputs[0] 0->1 at edge N -> irq = 1 at N+4; PENDING reads 32'h1; IN reads 32'h1.
- W1C and collision: pending = 32'h3, write PENDING=32'h1 -> reads 32'h2. Repeat the write in the same cycle a new bit-0 edge sets -> bit 0 stays 1.
- Falling edge and masks: FALL_EN=32'h8000_0000, bit 31 1->0 -> PENDING=32'h8000_0000. Then IRQ_EN=0 -> irq = 0 next cycle while pending is retained.
- Debounce (DEBOUNCE_DIV=4):
  - 3-cycle glitch on bit 5 -> IN unchanged, no pending.
  - Level held ≥ 8 cycles -> IN bit 5 updates within 12 cycles.
- Async reset mid-operation: assert sys_rst=0 between edges with pending = 32'hFF -> pending, irq and csr_do go to 0 immediately, without waiting for a clock edge.
